// File: rtl/pll_reconfig_responder.sv
// PLL reconfiguration responder: Avalon-MM start/status registers, streams a MIF
// image from ROM to the PLL scan logic, then pulses the PLL reset and waits for lock.
// All state advances only on clk_en; waitrequest holds every access off while busy.
module pll_reconfig_responder #(
  parameter int MIF_WORDS    = 46,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [8:0]  avs_address,
  input  logic        avs_write,
  input  logic        avs_read,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [8:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        pll_cfg_valid,
  output logic        pll_cfg_last,
  output logic [31:0] pll_cfg_data,
  input  logic        pll_cfg_ready,
  output logic        pll_areset,
  input  logic        pll_locked
);

  localparam int IDX_W  = (MIF_WORDS > 1) ? $clog2(MIF_WORDS) : 1;
  localparam int LCK_W  = $clog2(LOCK_TIMEOUT + 1);
  // One counter serves both the 4-cycle PLL reset pulse and the lock timeout.
  localparam int CNT_W  = (LCK_W > 3) ? LCK_W : 3;

  localparam logic [8:0] ADDR_STATUS = 9'h000;
  localparam logic [8:0] ADDR_START  = 9'h010;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_SEND      = 3'd3,
    S_PLL_RST   = 3'd4,
    S_WAIT_LOCK = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              waitreq_q, waitreq_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [8:0]        rom_addr_q, rom_addr_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              cfg_last_q, cfg_last_d;
  logic [31:0]       cfg_data_q, cfg_data_d;
  logic              areset_q, areset_d;

  logic              acc_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic              start;
  logic              hs;
  logic              is_last;
  logic [CNT_W-1:0]  cnt_inc;
  logic              lock_to;
  logic              busy;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  // Upper write-data bits carry no register content.
  assign unused_wdata = ^avs_writedata[31:9];

  // Access acceptance and stream/timer decode shared by the next-state and output logic.
  always_comb begin
    acc_ok  = clk_en && (state_q == S_IDLE) && !waitreq_q;
    wr_acc  = acc_ok && avs_write;
    // A write presented together with a read wins; the read is dropped.
    rd_acc  = acc_ok && avs_read && !avs_write;
    start   = wr_acc && (avs_address == ADDR_START);
    hs      = clk_en && (state_q == S_SEND) && cfg_valid_q && pll_cfg_ready;
    is_last = (idx_q == IDX_W'(MIF_WORDS - 1));
    cnt_inc = cnt_q + CNT_W'(1);
    lock_to = (cnt_inc == CNT_W'(LOCK_TIMEOUT));
    busy    = (state_q != S_IDLE);
    case (avs_address)
      ADDR_STATUS: rd_mux = {29'd0, timeout_err_q, pll_locked, busy};
      ADDR_START:  rd_mux = {23'd0, base_q};
      default:     rd_mux = 32'd0;
    endcase
  end

  // State and registered outputs; everything holds while clk_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      waitreq_q     <= 1'b0;
      rdata_q       <= '0;
      rom_addr_q    <= '0;
      cfg_valid_q   <= 1'b0;
      cfg_last_q    <= 1'b0;
      cfg_data_q    <= '0;
      areset_q      <= 1'b0;
    end else if (clk_en) begin
      state_q       <= state_d;
      base_q        <= base_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      waitreq_q     <= waitreq_d;
      rdata_q       <= rdata_d;
      rom_addr_q    <= rom_addr_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_last_q    <= cfg_last_d;
      cfg_data_q    <= cfg_data_d;
      areset_q      <= areset_d;
    end
  end

  // Next-state selection: at most one transition per enabled cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     state_d = S_WAIT_ROM;
      S_WAIT_ROM:  state_d = S_SEND;
      S_SEND:      if (hs) state_d = is_last ? S_PLL_RST : S_FETCH;
      S_PLL_RST:   if (cnt_q == CNT_W'(3)) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (pll_locked || lock_to) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values for the current state.
  always_comb begin
    base_d        = base_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    waitreq_d     = waitreq_q;
    rdata_d       = rdata_q;
    rom_addr_d    = rom_addr_q;
    cfg_valid_d   = cfg_valid_q;
    cfg_last_d    = cfg_last_q;
    cfg_data_d    = cfg_data_q;
    areset_d      = areset_q;
    case (state_q)
      S_IDLE: begin
        if (rd_acc) rdata_d = rd_mux;
        if (start) begin
          base_d        = avs_writedata[8:0];
          idx_d         = '0;
          timeout_err_d = 1'b0;
          waitreq_d     = 1'b1;
          // Address is presented during FETCH so ROM data is ready in WAIT_ROM.
          rom_addr_d    = avs_writedata[8:0];
        end
      end
      S_FETCH: begin
      end
      S_WAIT_ROM: begin
        cfg_data_d  = rom_data;
        cfg_valid_d = 1'b1;
        cfg_last_d  = is_last;
      end
      S_SEND: begin
        if (hs) begin
          cfg_valid_d = 1'b0;
          cfg_last_d  = 1'b0;
          if (is_last) begin
            areset_d = 1'b1;
            cnt_d    = '0;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            rom_addr_d = base_q + 9'(idx_q) + 9'd1;
          end
        end
      end
      S_PLL_RST: begin
        if (cnt_q == CNT_W'(3)) begin
          areset_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_LOCK: begin
        if (!pll_locked) begin
          cnt_d = cnt_inc;
          if (lock_to) timeout_err_d = 1'b1;
        end
      end
      S_DONE: begin
        waitreq_d = 1'b0;
      end
      default: begin
        base_d        = '0;
        idx_d         = '0;
        cnt_d         = '0;
        timeout_err_d = 1'b0;
        waitreq_d     = 1'b0;
        rdata_d       = '0;
        rom_addr_d    = '0;
        cfg_valid_d   = 1'b0;
        cfg_last_d    = 1'b0;
        cfg_data_d    = '0;
        areset_d      = 1'b0;
      end
    endcase
  end

  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = waitreq_q;
  assign rom_addr        = rom_addr_q;
  assign pll_cfg_valid   = cfg_valid_q;
  assign pll_cfg_last    = cfg_last_q;
  assign pll_cfg_data    = cfg_data_q;
  assign pll_areset      = areset_q;

endmodule

// File: doc/pll_reconfig_responder.md
PLL_RECONFIG_RESPONDER -- requirements
Module: pll_reconfig_responder

Interface
REQ-001 Parameter MIF_WORDS, default 46, words streamed per reconfiguration.
REQ-002 Parameter LOCK_TIMEOUT, default 1023, clk_en cycles allowed for pll_locked after PLL reset release.
REQ-003 clk  in  1  clock.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 clk_en  in  1  cycle qualifier; state, counters and registered outputs advance only when 1.
REQ-006 avs_address  in  9  Avalon-MM slave word address.
REQ-007 avs_write / avs_read  in  1 each  access strobes.
REQ-008 avs_writedata  in  32  write data.
REQ-009 avs_readdata  out  32  registered read data.
REQ-010 avs_waitrequest  out  1  registered stall.
REQ-011 rom_addr  out  9  MIF ROM address; rom_data  in  32, valid one clk_en cycle after rom_addr.
REQ-012 pll_cfg_valid / pll_cfg_last  out  1 each; pll_cfg_data  out  32; pll_cfg_ready  in  1  valid/ready stream to PLL scan logic.
REQ-013 pll_areset  out  1  PLL reset; pll_locked  in  1  PLL lock.

Function
REQ-014 Register map: 0x000 status RO {bit0 busy, bit1 pll_locked, bit2 timeout_err, others 0}; 0x010 start, write-only; 0x010 reads return base latched by last start; other addresses read 0, writes ignored.
REQ-015 States: IDLE, FETCH, WAIT_ROM, SEND, PLL_RST, WAIT_LOCK, DONE; one transition per clk_en cycle maximum.
REQ-016 IDLE: avs_waitrequest=0; read accepted -> avs_readdata updated next clk_en cycle; write to 0x010 accepted -> base=avs_writedata[8:0], idx=0, timeout_err=0, avs_waitrequest=1 next cycle, go FETCH.
REQ-017 Simultaneous avs_read and avs_write: write serviced, read ignored, avs_readdata unchanged.
REQ-018 avs_waitrequest SHALL stay 1 in every state except IDLE; accesses presented while 1 are not accepted and have no effect.
REQ-019 FETCH: rom_addr=(base+idx) mod 512 (9-bit wrap); go WAIT_ROM.
REQ-020 WAIT_ROM: capture rom_data into pll_cfg_data; go SEND.
REQ-021 SEND: pll_cfg_valid=1, pll_cfg_data stable, pll_cfg_last=1 iff idx==MIF_WORDS-1; on pll_cfg_ready: valid=0, and if last go PLL_RST else idx+1, go FETCH.
REQ-022 PLL_RST: pll_areset=1 for exactly 4 clk_en cycles, then 0; go WAIT_LOCK with lock counter=0.
REQ-023 WAIT_LOCK: pll_locked=1 -> DONE; else counter+1; counter==LOCK_TIMEOUT -> timeout_err=1, DONE.
REQ-024 DONE: avs_waitrequest=0 next cycle, go IDLE.
REQ-025 clk_en=0: all outputs hold; a pll_cfg_ready pulse while clk_en=0 is not a handshake.
REQ-026 Unreachable state encodings SHALL return to IDLE with reset output values.

Reset
REQ-027 reset_n low, any state: state=IDLE, avs_waitrequest=0, avs_readdata=0, rom_addr=0, pll_cfg_valid=0, pll_cfg_last=0, pll_cfg_data=0, pll_areset=0, base=0, idx=0, timeout_err=0, immediately and asynchronously.
REQ-028 Reset mid-stream SHALL drop pll_cfg_valid without completing the transfer; no resumption after release.

Verification
REQ-029 Write 0x010=92, ROM[i]=i, ready always 1, locked 5 cycles after areset falls -> 46 beats data 92..137, last on beat 46 only, areset 4 cycles, waitrequest high from cycle after write until DONE.
REQ-030 Write 0x010=500 -> rom_addr 500..511 then 0..33 (wrap).
REQ-031 pll_cfg_ready low 3 cycles on beat 10 -> pll_cfg_valid held, pll_cfg_data unchanged, no beat lost or duplicated.
REQ-032 pll_locked never 1, LOCK_TIMEOUT=15 -> DONE after 15 cycles in WAIT_LOCK; status read returns 0x4.
REQ-033 Read 0x000 during busy -> stalled until IDLE, then returns busy=0; write+read same cycle in IDLE -> write only.
REQ-034 reset_n low during SEND beat 20 -> all outputs at reset values same cycle; new start write after release runs a full 46-beat sequence.
